// File: rtl/noc_input_port.sv
// Router input port: 8-deep flit FIFO, XY route of the head flit, one-hot crossbar request and credit return.
// Optional NOC_INPORT_STATS_EN enables the saturating forwarded-flit counter on flit_cnt.
module noc_input_port #(
   parameter int         DEPTH   = 8,
   parameter logic [2:0] LOCAL_X = 3'd0,
   parameter logic [2:0] LOCAL_Y = 3'd0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [19:0]              datain,
   input  logic                     in_valid,
   output logic                     credit_out,
   output logic [4:0]               out_req,
   input  logic                     out_grant,
   output logic [19:0]              flit_out,
   output logic                     flit_out_valid,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     err,
   output logic [15:0]              flit_cnt,
   output logic                     dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

   typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

   logic [19:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_occ;
   state_t        r_state;
   logic [4:0]    r_route_q;
   logic          r_credit;
   logic          r_err;

   logic          w_empty;
   logic          w_full;
   logic [19:0]   w_head;
   logic [1:0]    w_head_type;
   logic [4:0]    w_route;
   logic [4:0]    w_req;
   logic          w_fwd;
   logic          w_discard;
   logic          w_deq;
   logic          w_enq;

   assign w_empty     = (r_occ == '0);
   assign w_full      = (r_occ == OCC_FULL);
   assign w_head      = r_mem[r_rptr];
   assign w_head_type = w_head[19:18];

   // Route bits are {Local,W,S,E,N}; X is resolved before Y.
   always_comb begin
      w_route = 5'b10000;
      if (w_head[17:15] > LOCAL_X)
         w_route = 5'b00010;
      else if (w_head[17:15] < LOCAL_X)
         w_route = 5'b01000;
      else if (w_head[14:12] > LOCAL_Y)
         w_route = 5'b00001;
      else if (w_head[14:12] < LOCAL_Y)
         w_route = 5'b00100;
   end

   // Crossbar handshake: out_req is the offer, out_grant is only honoured while
   // out_req is non-zero, and a flit leaves on every edge where both are high.
   assign w_req     = (r_state == S_ACTIVE && !w_empty) ? r_route_q : 5'b00000;
   assign w_fwd     = (w_req != 5'b00000) && out_grant;
   assign w_discard = (r_state == S_IDLE) && !w_empty && w_head_type[1];
   assign w_deq     = w_fwd || w_discard;
   assign w_enq     = in_valid && !w_full;

   always_ff @(posedge clk) begin
      if (!rst && w_enq)
         r_mem[r_wptr] <= datain;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_occ     <= '0;
         r_state   <= S_IDLE;
         r_route_q <= 5'b00000;
         r_credit  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_enq)
            r_wptr <= r_wptr + 1'b1;
         if (w_deq)
            r_rptr <= r_rptr + 1'b1;
         case ({w_enq, w_deq})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
         r_credit <= w_deq;
         if ((in_valid && w_full) || w_discard)
            r_err <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (!w_empty && !w_head_type[1]) begin
                  r_route_q <= w_route;
                  r_state   <= S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               // Single (00) and tail (11) flits close the packet.
               if (w_fwd && (w_head_type == 2'b00 || w_head_type == 2'b11)) begin
                  r_route_q <= 5'b00000;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef NOC_INPORT_STATS_EN
   logic [15:0] r_flit_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         r_flit_cnt <= 16'h0000;
      else if (w_fwd && r_flit_cnt != 16'hFFFF)
         r_flit_cnt <= r_flit_cnt + 16'h0001;
   end

   assign flit_cnt = r_flit_cnt;
`else
   assign flit_cnt = 16'h0000;
`endif

   assign credit_out     = r_credit;
   assign out_req        = w_req;
   assign flit_out       = w_empty ? 20'h00000 : w_head;
   assign flit_out_valid = (w_req != 5'b00000);
   assign occupancy      = r_occ;
   assign err            = r_err;
   assign dbg_state      = r_state;

endmodule

// File: tb/tb_noc_input_port.sv
// Bench for noc_input_port: directed vector table, hand sequences for the corner cases,
// and randomized traffic checked every cycle against a queue-based packet model.
module tb_noc_input_port;

   localparam int         DEPTH = 8;
   localparam logic [2:0] LX    = 3'd2;
   localparam logic [2:0] LY    = 3'd2;
`ifdef NOC_INPORT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [19:0] datain;
   logic        in_valid;
   logic        credit_out;
   logic [4:0]  out_req;
   logic        out_grant;
   logic [19:0] flit_out;
   logic        flit_out_valid;
   logic [3:0]  occupancy;
   logic        err;
   logic [15:0] flit_cnt;
   logic        dbg_state;

   noc_input_port #(.DEPTH(DEPTH), .LOCAL_X(LX), .LOCAL_Y(LY)) dut (
      .clk(clk), .rst(rst), .datain(datain), .in_valid(in_valid),
      .credit_out(credit_out), .out_req(out_req), .out_grant(out_grant),
      .flit_out(flit_out), .flit_out_valid(flit_out_valid), .occupancy(occupancy),
      .err(err), .flit_cnt(flit_cnt), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Packet-level model: FIFO contents, whether a packet is open and where it goes.
   logic [19:0] m_q[$];
   bit          m_open;
   logic [4:0]  m_route;
   bit          m_credit;
   bit          m_err;
   int          m_cnt;

   function automatic logic [4:0] xy_route(input logic [19:0] f);
      int dx = int'(f[17:15]);
      int dy = int'(f[14:12]);
      if (dx > int'(LX)) return 5'b00010;
      if (dx < int'(LX)) return 5'b01000;
      if (dy > int'(LY)) return 5'b00001;
      if (dy < int'(LY)) return 5'b00100;
      return 5'b10000;
   endfunction

   function automatic logic [4:0] m_req();
      return (m_open && m_q.size() > 0) ? m_route : 5'b00000;
   endfunction

   task automatic model_clear();
      m_q.delete();
      m_open   = 0;
      m_route  = 5'b00000;
      m_credit = 0;
      m_err    = 0;
      m_cnt    = 0;
   endtask

   task automatic model_check();
      chk("out_req", 32'(out_req), 32'(m_req()));
      chk("flit_out_valid", 32'(flit_out_valid), 32'(m_req() != 5'b00000));
      chk("flit_out", 32'(flit_out), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
      chk("occupancy", 32'(occupancy), 32'(m_q.size()));
      chk("credit_out", 32'(credit_out), 32'(m_credit));
      chk("err", 32'(err), 32'(m_err));
      chk("flit_cnt", 32'(flit_cnt), STATS ? 32'(m_cnt) : 32'h0);
      chk("state", 32'(dbg_state), 32'(m_open));
   endtask

   task automatic model_update();
      bit fwd, disc, start, full, enq;
      logic [19:0] f;
      fwd   = (m_req() != 5'b00000) && out_grant;
      disc  = !m_open && m_q.size() > 0 && m_q[0][19];
      start = !m_open && m_q.size() > 0 && !m_q[0][19];
      full  = (m_q.size() == DEPTH);
      enq   = in_valid && !full;
      m_credit = fwd || disc;
      if ((in_valid && full) || disc) m_err = 1;
      if (fwd) begin
         f = m_q.pop_front();
         if (m_cnt < 65535) m_cnt++;
         if (f[19:18] == 2'b00 || f[19:18] == 2'b11) m_open = 0;
      end
      if (disc) void'(m_q.pop_front());
      if (start) begin
         m_open  = 1;
         m_route = xy_route(m_q[0]);
      end
      if (enq) m_q.push_back(datain);
   endtask

   task automatic drive(input logic [19:0] d, input logic v, input logic g);
      datain    = d;
      in_valid  = v;
      out_grant = g;
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic step(input logic [19:0] d, input logic v, input logic g);
      drive(d, v, g);
      #1;
      model_check();
      advance();
   endtask

   task automatic do_reset();
      drive(20'h0, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_credit", 32'(credit_out), 32'h0);
      chk("rst_req", 32'(out_req), 32'h0);
      chk("rst_valid", 32'(flit_out_valid), 32'h0);
      chk("rst_occ", 32'(occupancy), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_cnt", 32'(flit_cnt), 32'h0);
      chk("rst_flit", 32'(flit_out), 32'h0);
      chk("rst_state", 32'(dbg_state), 32'h0);
      model_clear();
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [19:0] mk(input logic [1:0] t, input logic [2:0] x,
                                      input logic [2:0] y, input logic [11:0] p);
      return {t, x, y, p};
   endfunction

   typedef struct {
      logic [19:0] din;
      logic        vld;
      logic        gnt;
      logic [4:0]  req;
      logic        credit;
      logic [3:0]  occ;
      logic        st;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int credits;
      rst = 1'b1;
      drive(20'h0, 1'b0, 1'b0);
      model_clear();

      // Single flit to (3,0) goes East; 4-flit packet to (2,2) goes Local.
      vecs[0]  = '{mk(2'b00,3'd3,3'd0,12'h0A5), 1, 1, 5'b00000, 0, 4'd0, 0};
      vecs[1]  = '{20'h0,                      0, 1, 5'b00000, 0, 4'd1, 0};
      vecs[2]  = '{20'h0,                      0, 1, 5'b00010, 0, 4'd1, 1};
      vecs[3]  = '{20'h0,                      0, 1, 5'b00000, 1, 4'd0, 0};
      vecs[4]  = '{20'h0,                      0, 1, 5'b00000, 0, 4'd0, 0};
      vecs[5]  = '{mk(2'b01,3'd2,3'd2,12'h001), 1, 1, 5'b00000, 0, 4'd0, 0};
      vecs[6]  = '{mk(2'b10,3'd0,3'd0,12'h002), 1, 1, 5'b00000, 0, 4'd1, 0};
      vecs[7]  = '{mk(2'b10,3'd0,3'd0,12'h003), 1, 1, 5'b10000, 0, 4'd2, 1};
      vecs[8]  = '{mk(2'b11,3'd0,3'd0,12'h004), 1, 1, 5'b10000, 1, 4'd2, 1};
      vecs[9]  = '{20'h0,                      0, 1, 5'b10000, 1, 4'd2, 1};
      vecs[10] = '{20'h0,                      0, 1, 5'b10000, 1, 4'd1, 1};
      vecs[11] = '{20'h0,                      0, 1, 5'b00000, 1, 4'd0, 0};
      vecs[12] = '{20'h0,                      0, 1, 5'b00000, 0, 4'd0, 0};

      @(negedge clk);
      do_reset();

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].din, vecs[i].vld, vecs[i].gnt);
         #1;
         model_check();
         chk($sformatf("vec%0d_req", i), 32'(out_req), 32'(vecs[i].req));
         chk($sformatf("vec%0d_credit", i), 32'(credit_out), 32'(vecs[i].credit));
         chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(vecs[i].occ));
         chk($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(vecs[i].st));
         advance();
      end

      // Fill to DEPTH with grant low; the ninth flit is dropped.
      do_reset();
      for (int i = 0; i < 8; i++)
         step((i == 0) ? mk(2'b01,3'd5,3'd1,12'h100) : mk(2'b10,3'd0,3'd0,12'(i)), 1, 0);
      drive(mk(2'b10,3'd0,3'd0,12'h999), 1, 0);
      #1;
      model_check();
      chk("fill_occ8", 32'(occupancy), 32'd8);
      chk("fill_err_before", 32'(err), 32'h0);
      advance();
      drive(20'h0, 0, 0);
      #1;
      model_check();
      chk("fill_occ_after_drop", 32'(occupancy), 32'd8);
      chk("fill_err_after_drop", 32'(err), 32'h1);
      chk("fill_no_credit", 32'(credit_out), 32'h0);
      advance();
      for (int i = 0; i < 9; i++) step(20'h0, 0, 1);
      step(mk(2'b11,3'd0,3'd0,12'hEEE), 1, 1);
      for (int i = 0; i < 3; i++) step(20'h0, 0, 1);

      // Orphan body in IDLE: discarded with a credit and err.
      do_reset();
      step(mk(2'b10,3'd7,3'd7,12'h0B0), 1, 1);
      step(20'h0, 0, 1);
      drive(20'h0, 0, 1);
      #1;
      model_check();
      chk("orphan_credit", 32'(credit_out), 32'h1);
      chk("orphan_err", 32'(err), 32'h1);
      chk("orphan_req", 32'(out_req), 32'h0);
      chk("orphan_occ", 32'(occupancy), 32'h0);
      advance();

      // Steady enqueue+dequeue at occupancy 3; write pointer wraps past DEPTH.
      step(mk(2'b01,3'd1,3'd2,12'h300), 1, 0);
      step(mk(2'b10,3'd0,3'd0,12'h301), 1, 0);
      step(mk(2'b10,3'd0,3'd0,12'h302), 1, 0);
      credits = 0;
      for (int i = 0; i < 5; i++) begin
         drive(mk(2'b10,3'd0,3'd0,12'(12'h310 + i)), 1, 1);
         #1;
         model_check();
         chk($sformatf("simul_occ%0d", i), 32'(occupancy), 32'd3);
         chk($sformatf("simul_req%0d", i), 32'(out_req), 32'(5'b01000));
         credits += int'(credit_out);
         advance();
      end
      drive(mk(2'b11,3'd0,3'd0,12'h3FF), 1, 1);
      #1;
      model_check();
      credits += int'(credit_out);
      chk("simul_credits", 32'(credits), 32'd5);
      chk("simul_occ_end", 32'(occupancy), 32'd3);
      advance();
      for (int i = 0; i < 6; i++) step(20'h0, 0, 1);

      // Reset mid-packet after two grants.
      do_reset();
      step(mk(2'b01,3'd2,3'd3,12'h400), 1, 1);
      step(mk(2'b10,3'd0,3'd0,12'h401), 1, 1);
      step(mk(2'b10,3'd0,3'd0,12'h402), 1, 1);
      step(20'h0, 0, 1);
      drive(20'h0, 0, 0);
      #1;
      model_check();
      chk("midrst_cnt_before", 32'(flit_cnt), STATS ? 32'd2 : 32'd0);
      chk("midrst_req_before", 32'(out_req), 32'(5'b00001));
      do_reset();
      step(20'h0, 0, 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic [19:0] f;
         logic [1:0]  t;
         int          r;
         r = $urandom_range(0, 9);
         t = (r < 3) ? 2'b01 : (r < 5) ? 2'b00 : (r < 8) ? 2'b10 : 2'b11;
         f = mk(t, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 12'($urandom));
         step(f, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
         if (i == 300) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
